// File: rtl/ysyx_23060111_mem_arbiter_if.sv
// rtl/ysyx_23060111_mem_arbiter_if.sv - bus bundle between IFU/LSU requesters, the arbiter and the memory port
//
// Purpose: groups every handshake and data signal of the shared memory
//    arbiter so that one connection carries the IFU port, the LSU port and
//    the memory port.
// Modports:
//    slave  - arbiter view: takes IFU/LSU requests, returns responses,
//             drives the memory address/write signals, reads mem_rdata.
//    master - environment view: requesters plus the memory model.
// Signals:
//    ifu_req_valid/ifu_req_ready/ifu_addr        IFU read request
//    ifu_resp_valid/ifu_resp_ready/ifu_rdata     IFU read response
//    lsu_req_valid/lsu_req_ready/lsu_addr        LSU request
//    lsu_wen/lsu_wdata/lsu_wmask                 LSU write payload
//    lsu_resp_valid/lsu_resp_ready/lsu_rdata     LSU response (0 on write ack)
//    mem_raddr/mem_rdata                         memory read port
//    mem_waddr/mem_wdata/mem_wmask/mem_wen       memory write port

interface ysyx_23060111_mem_arbiter_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic        ifu_resp_ready;
   logic [31:0] ifu_rdata;

   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [31:0] lsu_wmask;
   logic        lsu_resp_valid;
   logic        lsu_resp_ready;
   logic [31:0] lsu_rdata;

   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_wmask;
   logic        mem_wen;

   modport slave (
      input  ifu_req_valid, ifu_addr, ifu_resp_ready,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
      input  mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_raddr, mem_waddr, mem_wdata, mem_wmask, mem_wen
   );

   modport master (
      output ifu_req_valid, ifu_addr, ifu_resp_ready,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
      output mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_raddr, mem_waddr, mem_wdata, mem_wmask, mem_wen
   );
endinterface

// File: rtl/ysyx_23060111_mem_arbiter.sv
// rtl/ysyx_23060111_mem_arbiter.sv - round-robin IFU/LSU arbiter for the single shared memory port
//
// Purpose: shares one memory port between the instruction fetch unit
//    (read-only) and the load/store unit (read/write). One transaction is in
//    flight at a time; each access spends LATENCY cycles in WAIT to model a
//    slow memory, then holds its response until the owner consumes it.
// Parameters:
//    LATENCY  cycles spent in WAIT per access, 1..15
// Ports:
//    clk   system clock
//    rst   asynchronous reset, active-high; aborts any access in flight
//    bus   ysyx_23060111_mem_arbiter_if.slave: IFU port, LSU port, memory port

module ysyx_23060111_mem_arbiter #(
   parameter int unsigned LATENCY = 1
) (
   input logic                         clk,
   input logic                         rst,
   ysyx_23060111_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic       SEL_IFU  = 1'b0;
   localparam logic       SEL_LSU  = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      state;
   state_t      state_nxt;

   logic        last_grant;
   logic        owner;
   logic        grant;
   logic        req_any;

   logic [31:0] addr_q;
   logic        wen_q;
   logic [31:0] wdata_q;
   logic [31:0] wmask_q;
   logic [3:0]  cnt;
   logic [31:0] ifu_rdata_q;
   logic [31:0] lsu_rdata_q;

   logic        accept;
   logic        wait_done;
   logic        ifu_ready;
   logic        lsu_ready;
   logic        ifu_resp;
   logic        lsu_resp;
   logic        wen_pulse;

   // On a tie the requester that did not win last time is chosen; after
   // reset last_grant points at the LSU so the IFU wins the first tie.
   always_comb begin
      req_any = bus.ifu_req_valid | bus.lsu_req_valid;
      grant   = SEL_IFU;
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
         grant = ~last_grant;
      end else if (bus.lsu_req_valid) begin
         grant = SEL_LSU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ifu_ready = 1'b0;
      lsu_ready = 1'b0;
      ifu_resp  = 1'b0;
      lsu_resp  = 1'b0;
      wen_pulse = 1'b0;
      accept    = 1'b0;
      wait_done = 1'b0;
      case (state)
         S_IDLE: begin
            // ready is only raised towards a valid requester, so any
            // pending request is a completed handshake this cycle
            if (req_any) begin
               ifu_ready = (grant == SEL_IFU);
               lsu_ready = (grant == SEL_LSU);
               accept    = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               wait_done = 1'b1;
               wen_pulse = wen_q;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (owner == SEL_IFU) begin
               ifu_resp = 1'b1;
               if (bus.ifu_resp_ready) begin
                  state_nxt = S_IDLE;
               end
            end else begin
               lsu_resp = 1'b1;
               if (bus.lsu_resp_ready) begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant  <= SEL_LSU;
         owner       <= SEL_IFU;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         cnt         <= '0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
      end else begin
         if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
            if (grant == SEL_LSU) begin
               addr_q  <= bus.lsu_addr;
               wen_q   <= bus.lsu_wen;
               wdata_q <= bus.lsu_wdata;
               wmask_q <= bus.lsu_wmask;
            end else begin
               addr_q  <= bus.ifu_addr;
               wen_q   <= 1'b0;
               wdata_q <= '0;
               wmask_q <= '0;
            end
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         // Read data is sampled on the last WAIT cycle; a write ack
         // returns zero so the LSU never sees stale read data.
         if (wait_done) begin
            if (owner == SEL_IFU) begin
               ifu_rdata_q <= bus.mem_rdata;
            end else begin
               lsu_rdata_q <= wen_q ? 32'h0 : bus.mem_rdata;
            end
         end
      end
   end

   assign bus.ifu_req_ready  = ifu_ready;
   assign bus.lsu_req_ready  = lsu_ready;
   assign bus.ifu_resp_valid = ifu_resp;
   assign bus.lsu_resp_valid = lsu_resp;
   assign bus.ifu_rdata      = ifu_rdata_q;
   assign bus.lsu_rdata      = lsu_rdata_q;

   // The memory sees one shared address for both ports; the write commits
   // on the edge that ends the single cycle wen_pulse is high.
   assign bus.mem_raddr = addr_q;
   assign bus.mem_waddr = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wmask = wmask_q;
   assign bus.mem_wen   = wen_pulse;

endmodule
